// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for X^E mod M, driving one shared
// external Montgomery multiplier and converting the result back to normal domain.
module modexp_ctrl #(
  parameter int N       = 512,
  parameter int E_WIDTH = 512,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N-1:0]       in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [N-1:0]       in_m,
  input  logic [N-1:0]       in_r,
  output logic [N-1:0]       result,
  output logic               done,
  output logic               busy,
  output logic               mm_start,
  output logic [N-1:0]       mm_a,
  output logic [N-1:0]       mm_b,
  output logic [N-1:0]       mm_m,
  input  logic [N-1:0]       mm_result,
  input  logic               mm_done
);

  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  typedef enum logic [3:0] {
    IDLE, SCAN, NEXT,
    SQ, SQ_GO, SQ_W,
    MUL, MUL_GO, MUL_W,
    POST, POST_GO, POST_W,
    DONE
  } state_t;

  state_t state, nxt;

  logic [N-1:0]       x_r, m_r, r_r, acc;
  logic [E_WIDTH-1:0] e_r;
  logic [CNT_W-1:0]   idx;
  logic               cur_bit;
  logic               idx_zero;

  assign cur_bit  = e_r[idx[IW-1:0]];
  assign idx_zero = (idx == '0);
  assign mm_m     = m_r;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = SCAN;
      SCAN:    if (cur_bit)       nxt = NEXT;
               else if (idx_zero) nxt = POST;
      NEXT:    nxt = idx_zero ? POST : SQ;
      SQ:      nxt = SQ_GO;
      SQ_GO:   nxt = SQ_W;
      SQ_W:    if (mm_done) nxt = cur_bit ? MUL : NEXT;
      MUL:     nxt = MUL_GO;
      MUL_GO:  nxt = MUL_W;
      MUL_W:   if (mm_done) nxt = NEXT;
      POST:    nxt = POST_GO;
      POST_GO: nxt = POST_W;
      POST_W:  if (mm_done) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE) && (state != DONE);
    done     = (state == DONE);
    mm_start = (state == SQ_GO) || (state == MUL_GO) || (state == POST_GO);
  end

  // Operand registers are loaded one cycle ahead of the *_GO pulse and left
  // untouched until the matching *_W state consumes mm_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r    <= '0;
      e_r    <= '0;
      m_r    <= '0;
      r_r    <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      mm_a   <= '0;
      mm_b   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_r <= in_x;
          e_r <= in_e;
          m_r <= in_m;
          r_r <= in_r;
          idx <= CNT_W'(E_WIDTH - 1);
        end
        SCAN: begin
          if (cur_bit)       acc <= x_r;
          else if (idx_zero) acc <= r_r;
          else               idx <= idx - CNT_W'(1);
        end
        NEXT: if (!idx_zero) idx <= idx - CNT_W'(1);
        SQ: begin
          mm_a <= acc;
          mm_b <= acc;
        end
        SQ_W:   if (mm_done) acc <= mm_result;
        MUL: begin
          mm_a <= acc;
          mm_b <= x_r;
        end
        MUL_W:  if (mm_done) acc <= mm_result;
        // Multiplying by plain 1 strips the Montgomery factor R.
        POST: begin
          mm_a <= acc;
          mm_b <= N'(1);
        end
        POST_W: if (mm_done) result <= mm_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural Montgomery multiplier, golden modpow,
// and a queue of expected results popped on each done pulse.
module tb_modexp_ctrl;
  localparam int N  = 512;
  localparam int EW = 512;
  localparam int CW = 10;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [N-1:0]  in_x, in_m, in_r, result, mm_a, mm_b, mm_m, mm_result;
  logic [EW-1:0] in_e;
  logic          done, busy, mm_start, mm_done;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  // Multiplier model state (written only by the model process)
  int           mm_cnt = 0;
  int           stab_err = 0;
  logic         mb = 1'b0;
  int           lat = 0;
  logic [N-1:0] la, lb, prod;

  modexp_ctrl #(.N(N), .E_WIDTH(EW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic [N-1:0] m);
    logic [N+1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] m);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    p = p % {{N{1'b0}}, m};
    return p[N-1:0];
  endfunction

  function automatic logic [N-1:0] modpow(input logic [N-1:0] x, input logic [EW-1:0] e,
                                          input logic [N-1:0] m);
    logic [N-1:0] r;
    r = N'(1) % m;
    for (int i = EW - 1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, x, m);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] to_mont(input logic [N-1:0] x, input logic [N-1:0] m);
    logic [2*N-1:0] t;
    t = {x, {N{1'b0}}} % {{N{1'b0}}, m};
    return t[N-1:0];
  endfunction

  function automatic int exp_starts(input logic [EW-1:0] e);
    int bl, pc;
    bl = 0;
    pc = 0;
    for (int i = EW - 1; i >= 0; i--)
      if (e[i]) begin
        pc++;
        if (bl == 0) bl = i + 1;
      end
    if (pc == 0) return 1;
    return (bl - 1) + (pc - 1) + 1;
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Behavioural multiplier: fixed latency, flags any operand change while busy.
  always @(posedge clk) begin
    if (reset) begin
      mb      <= 1'b0;
      mm_done <= 1'b0;
      lat     <= 0;
    end else begin
      mm_done <= 1'b0;
      if (mb) begin
        if (mm_a !== la || mm_b !== lb) stab_err <= stab_err + 1;
        if (lat == 0) begin
          mm_done   <= 1'b1;
          mm_result <= prod;
          mb        <= 1'b0;
        end else lat <= lat - 1;
      end
      if (mm_start) begin
        la     <= mm_a;
        lb     <= mm_b;
        prod   <= mont(mm_a, mm_b, mm_m);
        lat    <= LAT;
        mb     <= 1'b1;
        mm_cnt <= mm_cnt + 1;
      end
    end
  end

  task automatic launch(input logic [N-1:0] x, input logic [EW-1:0] e, input logic [N-1:0] m);
    @(posedge clk); #1;
    in_x  = to_mont(x, m);
    in_e  = e;
    in_m  = m;
    in_r  = to_mont(N'(1), m);
    exp_q.push_back(modpow(x, e, m));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out, output int cycles);
    timed_out = 1'b1;
    cycles = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (done) begin
        timed_out = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    in_x = '0; in_e = '0; in_m = '0; in_r = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result !== '0)   begin errors++; $display("FAIL reset_result: got %0h expected 0", result); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mm_start !== 1'b0) begin errors++; $display("FAIL reset_mm_start: got %b expected 0", mm_start); end
    reset = 1'b0;
  endtask

  task automatic test_small(input string name, input logic [EW-1:0] e, input int want_starts,
                            input logic [N-1:0] want_res);
    bit to; int cyc, c0; logic [N-1:0] exp;
    c0 = mm_cnt;
    launch(N'(3), e, N'(11));
    wait_done(to, cyc);
    exp = exp_q.pop_front();
    checks++; if (to) begin errors++; $display("FAIL %s_timeout: got no done expected done", name); end
    checks++; if (exp !== want_res) begin errors++; $display("FAIL %s_golden: got %0h expected %0h", name, exp, want_res); end
    checks++; if (result !== exp) begin errors++; $display("FAIL %s_result: got %0h expected %0h", name, result, exp); end
    checks++; if (mm_cnt - c0 !== want_starts) begin errors++; $display("FAIL %s_starts: got %0d expected %0d", name, mm_cnt - c0, want_starts); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b expected 0", name, busy); end
    if (e == '0) begin
      checks++; if (cyc < EW) begin errors++; $display("FAIL %s_scan_len: got %0d expected >= %0d", name, cyc, EW); end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_after_done: got done=%b busy=%b expected 0 0", name, done, busy); end
  endtask

  task automatic test_random();
    bit to; int cyc, c0; logic [N-1:0] m, x, exp; logic [EW-1:0] e;
    for (int v = 0; v < 20; v++) begin
      m = rand_wide();
      m[0] = 1'b1;
      m[N-1] = 1'b1;
      x = rand_wide() % m;
      e = '0;
      if (v == 0) e[0] = 1'b1;
      else e[31:0] = $urandom;
      c0 = mm_cnt;
      launch(x, e, m);
      wait_done(to, cyc);
      exp = exp_q.pop_front();
      if (v == 0) begin
        checks++; if (exp !== x) begin errors++; $display("FAIL rand_e1_golden: got %0h expected %0h", exp, x); end
      end
      checks++; if (to || result !== exp) begin errors++; $display("FAIL rand_result[%0d]: got %0h expected %0h", v, result, exp); end
      checks++; if (mm_cnt - c0 !== exp_starts(e)) begin errors++; $display("FAIL rand_starts[%0d]: got %0d expected %0d", v, mm_cnt - c0, exp_starts(e)); end
    end
  endtask

  task automatic test_ignored_start();
    bit to; int cyc, c0; logic [N-1:0] exp;
    c0 = mm_cnt;
    launch(N'(3), EW'(11), N'(11));
    repeat (6) @(posedge clk);
    #1;
    in_e = EW'(5);
    in_x = N'(7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(to, cyc);
    exp = exp_q.pop_front();
    checks++; if (to || result !== exp) begin errors++; $display("FAIL busy_start_result: got %0h expected %0h", result, exp); end
    checks++; if (mm_cnt - c0 !== 6) begin errors++; $display("FAIL busy_start_starts: got %0d expected 6", mm_cnt - c0); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL operand_stability: got %0d changes expected 0", stab_err); end
  endtask

  task automatic test_reset_mid();
    bit to, seen; int cyc; logic [N-1:0] exp;
    launch(N'(3), EW'(5), N'(11));
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      if (mm_start) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_reset_no_mm_start: got none expected pulse"); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got busy=%b done=%b mm_start=%b expected 0 0 0", busy, done, mm_start);
    end
    reset = 1'b0;
    exp = exp_q.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_reset_activity: got done/busy expected idle"); end
    launch(N'(3), EW'(5), N'(11));
    wait_done(to, cyc);
    exp = exp_q.pop_front();
    checks++; if (to || result !== N'(1) || exp !== N'(1)) begin
      errors++; $display("FAIL mid_reset_restart: got %0h expected 1", result);
    end
  endtask

  initial begin
    test_reset();
    test_small("e5", EW'(5), 4, N'(1));
    test_small("e11", EW'(11), 6, N'(3));
    test_small("e0", EW'(0), 1, N'(1));
    test_random();
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
